// File: rtl/mipi_rx_payload_unpacker_pkg.sv
// Shared definitions for the MIPI RX payload unpacker: header layout,
// payload-word record and serializer state encoding.
package mipi_rx_payload_unpacker_pkg;

  // Header value in bits [7:0] that marks a word as carrying UART payload.
  localparam logic [7:0] MARKER_DEF    = 8'hA5;
  // Largest legal byte count carried by one word.
  localparam int         MAX_BYTES_DEF = 5;

  // Bit positions of the fields inside a 64-bit RX word.
  localparam int MARKER_LSB  = 0;
  localparam int COUNT_LSB   = 8;
  localparam int PAYLOAD_LSB = 16;
  localparam int SEQ_LSB     = 56;
  localparam int PAYLOAD_W   = 40;

  // Serializer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } ser_state_t;

  // Record stored in the word FIFO: byte count and up to five payload bytes,
  // byte 0 in the least significant position.
  typedef struct packed {
    logic [7:0]           n;
    logic [PAYLOAD_W-1:0] payload;
  } pword_t;

endpackage

// File: rtl/mipi_rx_payload_unpacker_payload_word_fifo.sv
// payload_word_fifo: generic synchronous FIFO. Read data is registered on
// pop, so it is valid from the cycle after the pop. A pop in the same cycle
// as a push into a full FIFO does not make room for that push.
module mipi_rx_payload_unpacker_payload_word_fifo #(
  parameter int DW = 48,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int         DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_empty;
  logic [DW-1:0] r_rd_data;

  logic          w_full;
  logic          w_do_push;
  logic          w_do_pop;
  logic [AW:0]   w_count_nxt;

  assign w_full    = (r_count == DEPTH_C);
  assign w_do_push = push & ~w_full;
  assign w_do_pop  = pop & ~r_empty;

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + {{AW{1'b0}}, 1'b1};
      2'b01:   w_count_nxt = r_count - {{AW{1'b0}}, 1'b1};
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy, registered empty flag and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= {AW{1'b0}};
      r_rd_ptr  <= {AW{1'b0}};
      r_count   <= {(AW + 1){1'b0}};
      r_empty   <= 1'b1;
      r_rd_data <= {DW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + {{(AW - 1){1'b0}}, 1'b1};
      end
      if (w_do_pop) begin
        r_rd_ptr  <= r_rd_ptr + {{(AW - 1){1'b0}}, 1'b1};
        r_rd_data <= r_mem[r_rd_ptr];
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == {(AW + 1){1'b0}});
    end
  end

  assign pop_data = r_rd_data;
  assign full     = w_full;
  assign empty    = r_empty;

endmodule

// File: rtl/mipi_rx_payload_unpacker.sv
// mipi_rx_payload_unpacker: filters 64-bit MIPI RX words down to payload
// words, drops repeated copies, counts sequence gaps, buffers accepted words
// and serialises their payload bytes onto a valid/ready byte stream.
module mipi_rx_payload_unpacker
  import mipi_rx_payload_unpacker_pkg::*;
#(
  parameter int         WORD_FIFO_AW = 4,
  parameter logic [7:0] MARKER       = MARKER_DEF,
  parameter int         MAX_BYTES    = MAX_BYTES_DEF,
  parameter int         CNT_W        = 16
) (
  input  logic             rx_pixel_clk,
  input  logic             rst_n,
  input  logic             mipi_rx_valid,
  input  logic [63:0]      mipi_rx_data,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  input  logic             byte_ready,
  output logic             fifo_empty,
  output logic             busy,
  output logic [CNT_W-1:0] seq_err_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] fmt_err_cnt
);

  localparam logic [7:0] MAX_N = 8'(MAX_BYTES);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + {{(CNT_W - 1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // Stage 0 registers
  logic        r_s0_valid;
  logic [63:0] r_s0_data;

  // Stage 1 state
  logic             r_have_last;
  logic [7:0]       r_last_seq;
  logic [CNT_W-1:0] r_seq_err_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] r_fmt_err_cnt;

  // Serializer state
  ser_state_t  r_state;
  logic        r_byte_valid;
  logic [7:0]  r_byte_data;
  logic [7:0]  r_n;
  logic [2:0]  r_idx;
  logic [31:0] r_shift;

  // Header fields and classification of the stage-0 word
  logic [7:0]           w_marker;
  logic [7:0]           w_n;
  logic [7:0]           w_seq;
  logic [PAYLOAD_W-1:0] w_payload;
  logic                 w_marker_ok;
  logic                 w_fmt_bad;
  logic                 w_fmt_err;
  logic                 w_dup;
  logic                 w_accept;
  logic                 w_gap;
  logic                 w_push;
  logic                 w_drop;

  // FIFO interface
  pword_t w_push_word;
  pword_t w_pop_word;
  logic   w_full;
  logic   w_fifo_empty;
  logic   w_pop;
  logic   w_last_byte;

  // Stage 0: capture every RX word unconditionally.
  always_ff @(posedge rx_pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0_valid <= 1'b0;
      r_s0_data  <= 64'd0;
    end else begin
      r_s0_valid <= mipi_rx_valid;
      r_s0_data  <= mipi_rx_data;
    end
  end

  assign w_marker  = r_s0_data[MARKER_LSB +: 8];
  assign w_n       = r_s0_data[COUNT_LSB +: 8];
  assign w_seq     = r_s0_data[SEQ_LSB +: 8];
  assign w_payload = r_s0_data[PAYLOAD_LSB +: PAYLOAD_W];

  // Non-marker words are video filler and are ignored without any count.
  // A bad byte count is flagged before duplicate/sequence checks so that a
  // malformed word never updates the sequence tracker.
  assign w_marker_ok = r_s0_valid & (w_marker == MARKER);
  assign w_fmt_bad   = (w_n == 8'd0) | (w_n > MAX_N);
  assign w_fmt_err   = w_marker_ok & w_fmt_bad;
  assign w_dup       = w_marker_ok & ~w_fmt_bad & r_have_last & (w_seq == r_last_seq);
  assign w_accept    = w_marker_ok & ~w_fmt_bad & ~w_dup;
  assign w_gap       = w_accept & r_have_last & (w_seq != (r_last_seq + 8'd1));
  assign w_push      = w_accept & ~w_full;
  assign w_drop      = w_accept & w_full;

  assign w_push_word = {w_n, w_payload};

  // Stage 1: sequence tracking and saturating event counters. The tracker
  // follows every accepted word, including one lost to a full FIFO, so a
  // drop is not reported a second time as a sequence gap.
  always_ff @(posedge rx_pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_have_last   <= 1'b0;
      r_last_seq    <= 8'd0;
      r_seq_err_cnt <= {CNT_W{1'b0}};
      r_drop_cnt    <= {CNT_W{1'b0}};
      r_fmt_err_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_accept) begin
        r_have_last <= 1'b1;
        r_last_seq  <= w_seq;
      end
      if (w_gap) begin
        r_seq_err_cnt <= sat_inc(r_seq_err_cnt);
      end
      if (w_drop) begin
        r_drop_cnt <= sat_inc(r_drop_cnt);
      end
      if (w_fmt_err) begin
        r_fmt_err_cnt <= sat_inc(r_fmt_err_cnt);
      end
    end
  end

  mipi_rx_payload_unpacker_payload_word_fifo #(
    .DW ($bits(pword_t)),
    .AW (WORD_FIFO_AW)
  ) u_payload_word_fifo (
    .clk       (rx_pixel_clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_word),
    .pop       (w_pop),
    .pop_data  (w_pop_word),
    .full      (w_full),
    .empty     (w_fifo_empty)
  );

  // The FIFO read data is registered, so the serializer pops in IDLE and
  // picks the word up one cycle later in LOAD.
  assign w_pop       = (r_state == ST_IDLE) & ~w_fifo_empty;
  assign w_last_byte = ({5'd0, r_idx} == (r_n - 8'd1));

  // Serializer FSM: pop a word, present its bytes one at a time and hold the
  // current byte until the consumer takes it.
  always_ff @(posedge rx_pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_byte_valid <= 1'b0;
      r_byte_data  <= 8'd0;
      r_n          <= 8'd0;
      r_idx        <= 3'd0;
      r_shift      <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_fifo_empty) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_n          <= w_pop_word.n;
          r_idx        <= 3'd0;
          r_byte_data  <= w_pop_word.payload[7:0];
          r_shift      <= w_pop_word.payload[39:8];
          r_byte_valid <= 1'b1;
          r_state      <= ST_EMIT;
        end
        ST_EMIT: begin
          if (r_byte_valid && byte_ready) begin
            if (w_last_byte) begin
              r_byte_valid <= 1'b0;
              r_state      <= ST_IDLE;
            end else begin
              r_idx       <= r_idx + 3'd1;
              r_byte_data <= r_shift[7:0];
              r_shift     <= {8'd0, r_shift[31:8]};
            end
          end
        end
        default: begin
          r_byte_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign byte_valid  = r_byte_valid;
  assign byte_data   = r_byte_data;
  assign fifo_empty  = w_fifo_empty;
  assign busy        = ~w_fifo_empty | (r_state != ST_IDLE);
  assign seq_err_cnt = r_seq_err_cnt;
  assign drop_cnt    = r_drop_cnt;
  assign fmt_err_cnt = r_fmt_err_cnt;

endmodule

// File: tb/tb_mipi_rx_payload_unpacker.sv
// Testbench for mipi_rx_payload_unpacker: directed scenarios plus a random
// phase, checked against a word-level reference model of the filter rules
// and an expected byte queue.
module tb_mipi_rx_payload_unpacker;

  logic        rx_pixel_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mipi_rx_valid = 1'b0;
  logic [63:0] mipi_rx_data = 64'd0;
  logic        byte_ready = 1'b1;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        fifo_empty;
  logic        busy;
  logic [15:0] seq_err_cnt;
  logic [15:0] drop_cnt;
  logic [15:0] fmt_err_cnt;

  mipi_rx_payload_unpacker dut (
    .rx_pixel_clk  (rx_pixel_clk),
    .rst_n         (rst_n),
    .mipi_rx_valid (mipi_rx_valid),
    .mipi_rx_data  (mipi_rx_data),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_ready    (byte_ready),
    .fifo_empty    (fifo_empty),
    .busy          (busy),
    .seq_err_cnt   (seq_err_cnt),
    .drop_cnt      (drop_cnt),
    .fmt_err_cnt   (fmt_err_cnt)
  );

  always #5 rx_pixel_clk = ~rx_pixel_clk;

  int n_checks = 0;
  int n_errors = 0;
  int bytes_out = 0;

  // Reference model state
  bit         m_have_last = 1'b0;
  logic [7:0] m_last = 8'd0;
  int         m_seq = 0;
  int         m_fmt = 0;
  int         m_drop = 0;
  logic [7:0] exp_q[$];

  bit rand_mode = 1'b0;
  bit ready_force = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input logic [7:0] seq, input logic [7:0] n,
                                     input logic [39:0] pl, input logic [7:0] mkr);
    return {seq, pl, n, mkr};
  endfunction

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Word-level filter rules; accepted bytes go to the expected queue.
  task automatic model_word(input logic [63:0] d, input bit will_drop);
    logic [7:0]  mkr;
    logic [7:0]  n;
    logic [7:0]  seq;
    logic [39:0] pl;
    mkr = d[7:0];
    n   = d[15:8];
    pl  = d[55:16];
    seq = d[63:56];
    if (mkr != 8'hA5) return;
    if (n == 8'd0 || n > 8'd5) begin
      m_fmt = sat(m_fmt);
      return;
    end
    if (m_have_last && seq == m_last) return;
    if (m_have_last && seq != m_last + 8'd1) m_seq = sat(m_seq);
    m_last = seq;
    m_have_last = 1'b1;
    if (will_drop) begin
      m_drop = sat(m_drop);
    end else begin
      for (int k = 0; k < int'(n); k++) exp_q.push_back(pl[8*k +: 8]);
    end
  endtask

  task automatic model_reset();
    m_have_last = 1'b0;
    m_last = 8'd0;
    m_seq = 0;
    m_fmt = 0;
    m_drop = 0;
    exp_q.delete();
  endtask

  // Byte-ready driver: forced level or random backpressure.
  always @(posedge rx_pixel_clk) begin
    #1;
    byte_ready = rand_mode ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Compare process: every accepted byte against the model queue, and
  // stability of a stalled byte.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;
  always @(negedge rx_pixel_clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_hold_valid", {31'd0, byte_valid}, 32'd1);
        chk("stall_hold_data", {24'd0, byte_data}, {24'd0, prev_data});
      end
      if (byte_valid && byte_ready) begin
        bytes_out++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected no byte at %0t", byte_data, $time);
        end else begin
          chk("byte_stream", {24'd0, byte_data}, {24'd0, exp_q.pop_front()});
        end
      end
      prev_stall = byte_valid && !byte_ready;
      prev_data = byte_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Present a word for cyc consecutive cycles (entered at posedge+1).
  task automatic send(input logic [63:0] d, input int cyc, input bit will_drop);
    for (int i = 0; i < cyc; i++) begin
      mipi_rx_data = d;
      mipi_rx_valid = 1'b1;
      model_word(d, will_drop);
      @(posedge rx_pixel_clk);
      #1;
    end
    mipi_rx_valid = 1'b0;
  endtask

  // Wait for the expected stream to empty, then check idle state and counters.
  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge rx_pixel_clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_drain: %0d bytes outstanding, 0 required", tag, exp_q.size());
      exp_q.delete();
    end
    repeat (6) @(negedge rx_pixel_clk);
    chk({tag, "_byte_valid"}, {31'd0, byte_valid}, 32'd0);
    chk({tag, "_fifo_empty"}, {31'd0, fifo_empty}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_seq_err"}, {16'd0, seq_err_cnt}, m_seq);
    chk({tag, "_drop"}, {16'd0, drop_cnt}, m_drop);
    chk({tag, "_fmt_err"}, {16'd0, fmt_err_cnt}, m_fmt);
    @(posedge rx_pixel_clk);
    #1;
  endtask

  // Reset pulse between posedges (entered at posedge+1).
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    mipi_rx_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge rx_pixel_clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    int t;
    logic [7:0]  s0;
    logic [7:0]  s;
    logic [7:0]  n;
    logic [7:0]  mkr;
    logic [39:0] pl;
    int r;
    int reps;

    // Reset state
    repeat (2) @(posedge rx_pixel_clk);
    #1;
    chk("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    chk("rst_byte_data", {24'd0, byte_data}, 32'd0);
    chk("rst_fifo_empty", {31'd0, fifo_empty}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_seq_err", {16'd0, seq_err_cnt}, 32'd0);
    chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
    chk("rst_fmt_err", {16'd0, fmt_err_cnt}, 32'd0);
    rst_n = 1'b1;
    @(posedge rx_pixel_clk);
    #1;

    // Single word: latency and back-to-back bytes
    send(mk(8'h01, 8'd3, 40'h00_004C_4548, 8'hA5), 1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge rx_pixel_clk);
      chk("t1_latency_idle", {31'd0, byte_valid}, 32'd0);
    end
    @(negedge rx_pixel_clk);
    chk("t1_b0_valid", {31'd0, byte_valid}, 32'd1);
    chk("t1_b0", {24'd0, byte_data}, 32'h48);
    @(negedge rx_pixel_clk);
    chk("t1_b1", {24'd0, byte_data}, 32'h45);
    @(negedge rx_pixel_clk);
    chk("t1_b2", {24'd0, byte_data}, 32'h4C);
    @(negedge rx_pixel_clk);
    chk("t1_end_valid", {31'd0, byte_valid}, 32'd0);
    drain("t1");

    // Held duplicate followed by the next sequence number
    do_reset();
    base = bytes_out;
    send(mk(8'h01, 8'd3, 40'h00_004C_4548, 8'hA5), 200, 1'b0);
    send(mk(8'h02, 8'd1, 40'h00_0000_004F, 8'hA5), 1, 1'b0);
    drain("t2");
    chk("t2_byte_count", bytes_out - base, 32'd4);
    chk("t2_seq_err_lit", {16'd0, seq_err_cnt}, 32'd0);

    // Sequence gap, then wrap FF -> 00
    send(mk(8'h05, 8'd2, 40'h00_0000_BEEF, 8'hA5), 1, 1'b0);
    drain("t3a");
    chk("t3_gap_lit", {16'd0, seq_err_cnt}, 32'd1);
    send(mk(8'hFF, 8'd1, 40'h00_0000_0011, 8'hA5), 1, 1'b0);
    send(mk(8'h00, 8'd2, 40'h00_0000_2233, 8'hA5), 1, 1'b0);
    drain("t3b");
    chk("t3_wrap_lit", {16'd0, seq_err_cnt}, 32'd2);

    // Backpressure overflow: 20 words, 17 held, 3 dropped
    ready_force = 1'b0;
    repeat (3) @(posedge rx_pixel_clk);
    #1;
    s0 = m_last + 8'd1;
    for (int i = 0; i < 20; i++) begin
      pl[31:0] = $urandom;
      pl[39:32] = 8'($urandom);
      send(mk(s0 + 8'(i), 8'(i % 5 + 1), pl, 8'hA5), 1, (i >= 17));
    end
    repeat (5) @(negedge rx_pixel_clk);
    chk("t4_drop_lit", {16'd0, drop_cnt}, 32'd3);
    chk("t4_fifo_nonempty", {31'd0, fifo_empty}, 32'd0);
    chk("t4_stalled_valid", {31'd0, byte_valid}, 32'd1);
    @(posedge rx_pixel_clk);
    #1;
    ready_force = 1'b1;
    drain("t4");

    // Filler and malformed words
    do_reset();
    base = bytes_out;
    send(mk(8'h33, 8'd3, 40'h00_0012_3456, 8'h00), 1, 1'b0);
    repeat (6) @(negedge rx_pixel_clk);
    chk("t5_filler_seq", {16'd0, seq_err_cnt}, 32'd0);
    chk("t5_filler_fmt", {16'd0, fmt_err_cnt}, 32'd0);
    chk("t5_filler_drop", {16'd0, drop_cnt}, 32'd0);
    @(posedge rx_pixel_clk);
    #1;
    send(mk(8'h34, 8'd0, 40'h00_0012_3456, 8'hA5), 1, 1'b0);
    send(mk(8'h35, 8'd6, 40'h00_0012_3456, 8'hA5), 1, 1'b0);
    drain("t5");
    chk("t5_fmt_lit", {16'd0, fmt_err_cnt}, 32'd2);
    chk("t5_no_bytes", bytes_out - base, 32'd0);

    // Asynchronous reset in the middle of a 5-byte word
    send(mk(8'h10, 8'd5, 40'h55_4433_2211, 8'hA5), 1, 1'b0);
    t = 0;
    while (!byte_valid && t < 20) begin
      @(negedge rx_pixel_clk);
      t++;
    end
    chk("t6_started", {31'd0, byte_valid}, 32'd1);
    @(negedge rx_pixel_clk);
    @(posedge rx_pixel_clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_async_valid", {31'd0, byte_valid}, 32'd0);
    chk("t6_fifo_empty", {31'd0, fifo_empty}, 32'd1);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge rx_pixel_clk);
    #1;
    rst_n = 1'b1;
    send(mk(8'h77, 8'd2, 40'h00_0000_ABCD, 8'hA5), 1, 1'b0);
    drain("t6");
    chk("t6_seq_err_lit", {16'd0, seq_err_cnt}, 32'd0);

    // Random traffic with random backpressure
    rand_mode = 1'b1;
    for (int w = 0; w < 150; w++) begin
      r = $urandom_range(0, 9);
      s = m_last + 8'd1;
      n = 8'($urandom_range(1, 5));
      mkr = 8'hA5;
      pl[31:0] = $urandom;
      pl[39:32] = 8'($urandom);
      reps = 1;
      case (r)
        0: reps = $urandom_range(2, 5);
        6: s = m_last + 8'($urandom_range(2, 200));
        7: s = m_last;
        8: begin
          mkr = 8'($urandom_range(0, 255));
          if (mkr == 8'hA5) mkr = 8'h5A;
        end
        9: n = ($urandom_range(0, 1) != 0) ? 8'd0 : 8'($urandom_range(6, 255));
        default: reps = 1;
      endcase
      send(mk(s, n, pl, mkr), reps, 1'b0);
      repeat ($urandom_range(10, 20)) @(posedge rx_pixel_clk);
      #1;
    end
    rand_mode = 1'b0;
    drain("rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
